pc_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch for the mini-MIPS core.
- Each cycle it picks the next PC from one of these sources: sequential increment, jump, taken branch, exception vector or exception return.
- It drives a request/acknowledge handshake to instruction memory and flushes the front end on every redirect.
- It sits between the control/hazard unit and instruction memory, and replaces the free-running PC register.

---
 rtl/pc_sequencer_if.sv | 39 +++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle for pc_sequencer.
// The sequencer is the master: it takes the redirect and hazard inputs from
// control and drives the fetch request and status outputs. The slave modport
// is the control/imem/decode side.
//   stall, jump, jump_target, branch_taken, branch_target,
//   exc_req, exc_pc, eret, if_ack                  -> into the sequencer
//   if_req, if_addr, if_valid, if_pc, pc, flush,
//   epc, addr_err                                  <- out of the sequencer
interface pc_sequencer_if;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        eret;
  logic        if_ack;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] epc;
  logic        addr_err;

  modport master (
    input  stall, jump, jump_target, branch_taken, branch_target,
           exc_req, exc_pc, eret, if_ack,
    output if_req, if_addr, if_valid, if_pc, pc, flush, epc, addr_err
  );

  modport slave (
    output stall, jump, jump_target, branch_taken, branch_target,
           exc_req, exc_pc, eret, if_ack,
    input  if_req, if_addr, if_valid, if_pc, pc, flush, epc, addr_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer for the mini-MIPS core.
// Picks the next PC from one of five sources: sequential +4, jump, taken
// branch, exception vector or exception return. It runs a req/ack handshake
// to instruction memory and flushes decode on every redirect.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - pc_sequencer_if.master (redirect inputs, fetch handshake, status)
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        flush_q, flush_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] redir_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      flush_q    <= flush_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = 1'b0;
    flush_d    = 1'b0;
    addr_err_d = 1'b0;
    // jump outranks branch when both are asserted
    redir_tgt  = bus.jump ? bus.jump_target : bus.branch_target;

    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (bus.exc_req) begin
          epc_d   = bus.exc_pc;
          pc_d    = EXC_VECTOR;
          flush_d = 1'b1;
          state_d = FLUSH;
        end else if (bus.eret) begin
          pc_d    = epc_q;
          flush_d = 1'b1;
          state_d = FLUSH;
        end else if (bus.jump || bus.branch_taken) begin
          flush_d = 1'b1;
          state_d = FLUSH;
          if (redir_tgt[1:0] == 2'b00) begin
            pc_d = redir_tgt;
          end else begin
            // misaligned target traps; the bad address is kept in epc
            epc_d      = redir_tgt;
            pc_d       = EXC_VECTOR;
            addr_err_d = 1'b1;
          end
        end else if (!bus.stall && bus.if_ack) begin
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end
      end
      FLUSH: begin
        // only a new exception can extend the bubble
        if (bus.exc_req) begin
          epc_d   = bus.exc_pc;
          pc_d    = EXC_VECTOR;
          flush_d = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.if_req   = (state_q == FETCH) && !bus.stall;
  assign bus.if_addr  = pc_q;
  assign bus.pc       = pc_q;
  assign bus.if_valid = if_valid_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.flush    = flush_q;
  assign bus.epc      = epc_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed stimulus pushes the expected fetches and
// redirects into queues; a monitor compares them on the falling edge.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst;
  pc_sequencer_if bus();

  pc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        ae;
  } redir_t;

  logic [31:0] fq[$];
  redir_t      rq[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic push_r(input logic [31:0] p, input logic [31:0] e, input logic a);
    redir_t r;
    r.pc = p; r.epc = e; r.ae = a;
    rq.push_back(r);
  endtask

  // monitor: registered outputs are stable at the falling edge
  always @(negedge clk) begin
    if (bus.if_valid) begin
      if (fq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_if_valid: got if_pc %h expected no fetch", bus.if_pc);
      end else begin
        check("if_pc", bus.if_pc, fq.pop_front());
      end
    end
    if (bus.flush) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_flush: got pc %h expected no flush", bus.pc);
      end else begin
        redir_t r;
        r = rq.pop_front();
        check("redir_pc", bus.pc, r.pc);
        check("redir_epc", bus.epc, r.epc);
        check("redir_addr_err", {31'd0, bus.addr_err}, {31'd0, r.ae});
      end
    end else if (bus.addr_err) begin
      total++; bad++;
      $display("FAIL addr_err_no_flush: got addr_err 1 expected 0");
    end
  end

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.jump = 0; bus.jump_target = '0;
    bus.branch_taken = 0; bus.branch_target = '0;
    bus.exc_req = 0; bus.exc_pc = '0; bus.eret = 0; bus.if_ack = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("rst_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_epc", bus.epc, 32'h0);
    check("rst_addr_err", {31'd0, bus.addr_err}, 32'd0);
    check("rst_if_req", {31'd0, bus.if_req}, 32'd0);

    // BOOT cycle, if_ack tied high
    nxt(); rst = 0; bus.if_ack = 1; #1;
    check("boot_if_req", {31'd0, bus.if_req}, 32'd0);
    check("boot_pc", bus.pc, 32'h0);
    nxt(); fq.push_back(32'h0); #1;
    check("first_if_req", {31'd0, bus.if_req}, 32'd1);
    check("first_if_addr", bus.if_addr, 32'h0);
    nxt(); fq.push_back(32'h4);
    nxt(); fq.push_back(32'h8);
    nxt(); fq.push_back(32'hC);

    // stall three cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      nxt(); bus.stall = 1; #1;
      check("stall_pc", bus.pc, 32'h10);
      check("stall_if_req", {31'd0, bus.if_req}, 32'd0);
    end
    nxt(); bus.stall = 0; fq.push_back(32'h10); #1;
    check("resume_if_addr", bus.if_addr, 32'h10);

    // jump and branch together with if_ack: jump wins, fetch of 0x14 dropped
    nxt();
    bus.jump = 1; bus.jump_target = 32'h200;
    bus.branch_taken = 1; bus.branch_target = 32'h300;
    push_r(32'h200, 32'h0, 1'b0);
    // FLUSH bubble: redirects here must be ignored
    nxt();
    bus.jump = 1; bus.jump_target = 32'h400; bus.branch_taken = 0; bus.eret = 1; #1;
    check("bubble_if_req", {31'd0, bus.if_req}, 32'd0);
    nxt(); bus.jump = 0; bus.eret = 0; fq.push_back(32'h200); #1;
    check("target_if_addr", bus.if_addr, 32'h200);

    // exception beats eret
    nxt(); bus.if_ack = 0; bus.exc_req = 1; bus.exc_pc = 32'h44; bus.eret = 1;
    push_r(32'h80, 32'h44, 1'b0);
    nxt(); bus.exc_req = 0; bus.eret = 0;
    nxt(); #1; check("exc_pc_vec", bus.pc, 32'h80);
    bus.eret = 1; push_r(32'h44, 32'h44, 1'b0);
    nxt(); bus.eret = 0;

    // misaligned branch traps
    nxt(); #1; check("eret_pc", bus.pc, 32'h44);
    bus.branch_taken = 1; bus.branch_target = 32'h102;
    push_r(32'h80, 32'h102, 1'b1);
    // exception during FLUSH extends it
    nxt(); bus.branch_taken = 0; bus.exc_req = 1; bus.exc_pc = 32'h60;
    push_r(32'h80, 32'h60, 1'b0);
    nxt(); bus.exc_req = 0; #1;
    check("flush_ext_if_req", {31'd0, bus.if_req}, 32'd0);

    // wrap-around of pc+4
    nxt(); #1;
    check("post_flush_if_req", {31'd0, bus.if_req}, 32'd1);
    bus.jump = 1; bus.jump_target = 32'hFFFF_FFFC;
    push_r(32'hFFFF_FFFC, 32'h60, 1'b0);
    nxt(); bus.jump = 0;
    nxt(); bus.if_ack = 1; fq.push_back(32'hFFFF_FFFC); #1;
    check("wrap_if_addr", bus.if_addr, 32'hFFFF_FFFC);
    nxt(); fq.push_back(32'h0); #1;
    check("wrap_pc", bus.pc, 32'h0);

    // reset mid-fetch at pc=4 drops the transaction
    nxt(); rst = 1; #1;
    check("midrst_pc", bus.pc, 32'h0);
    check("midrst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("midrst_if_req", {31'd0, bus.if_req}, 32'd0);
    check("midrst_epc", bus.epc, 32'h0);
    nxt(); nxt(); rst = 0; bus.if_ack = 0;
    nxt(); nxt(); #1;
    check("fetch_queue_empty", fq.size(), 32'd0);
    check("redir_queue_empty", rq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
